button_debounce: RTL and testbench

BUTTON_DEBOUNCE -- requirements
Module: button_debounce

---
 rtl/button_debounce.sv | 101 ++++++++++
 tb/tb_button_debounce.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/button_debounce.sv
// Debounces a raw asynchronous push-button: two-flop synchronizer, a four-state
// stability FSM, registered level/press/release outputs and a press counter.
module button_debounce #(
  parameter int STABLE_COUNT = 50000,
  parameter int CNT_WIDTH    = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_in,
  output logic       btn_level,
  output logic       btn_press,
  output logic       btn_release,
  output logic [7:0] press_count
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CHK_PRESS = 2'd1,
    PRESSED   = 2'd2,
    CHK_REL   = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_COUNT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  logic                 s1;
  logic                 s2;
  state_t               state;
  logic [CNT_WIDTH-1:0] cnt;

  // Synchronizer, stability FSM and all registered outputs share one clocked block.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1          <= 1'b0;
      s2          <= 1'b0;
      state       <= IDLE;
      cnt         <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      press_count <= 8'd0;
    end else begin
      s1          <= btn_in;
      s2          <= s1;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (s2) begin
            state <= CHK_PRESS;
          end else begin
            state <= IDLE;
          end
        end
        CHK_PRESS: begin
          if (!s2) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            // Press accepted: level, pulse and count all move on this edge.
            state       <= PRESSED;
            cnt         <= '0;
            btn_level   <= 1'b1;
            btn_press   <= 1'b1;
            press_count <= press_count + 8'd1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        PRESSED: begin
          cnt <= '0;
          if (!s2) begin
            state <= CHK_REL;
          end else begin
            state <= PRESSED;
          end
        end
        CHK_REL: begin
          if (s2) begin
            state <= PRESSED;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state       <= IDLE;
            cnt         <= '0;
            btn_level   <= 1'b0;
            btn_release <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state     <= IDLE;
          cnt       <= '0;
          btn_level <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_debounce.sv
// Self-checking bench for button_debounce (STABLE_COUNT=4): a delay-and-run-length
// reference model compared every cycle, plus hand-computed directed expectations.
module tb_button_debounce;

  localparam int SC = 4;

  logic       clk;
  logic       rst_n;
  logic       btn_in;
  logic       btn_level;
  logic       btn_press;
  logic       btn_release;
  logic [7:0] press_count;

  int compared;
  int mismatched;
  int press_pulses;
  int release_pulses;
  bit checking;

  button_debounce #(.STABLE_COUNT(SC), .CNT_WIDTH(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_in      (btn_in),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .press_count (press_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the button value seen two edges late must disagree with the accepted
  // level on SC+1 consecutive edges before the level flips.
  typedef struct {
    logic [1:0] dly;
    int         run;
    logic       level;
    logic       press;
    logic       rel;
    logic [7:0] count;
  } mstate_t;

  mstate_t m;

  function automatic mstate_t model_step(mstate_t c, logic b, logic r);
    mstate_t n;
    logic    seen;
    n = c;
    if (!r) begin
      n.dly = 2'b00; n.run = 0; n.level = 1'b0;
      n.press = 1'b0; n.rel = 1'b0; n.count = 8'd0;
    end else begin
      seen    = c.dly[1];
      n.dly   = {c.dly[0], b};
      n.press = 1'b0;
      n.rel   = 1'b0;
      if (seen != c.level) begin
        n.run = c.run + 1;
        if (n.run == SC + 1) begin
          n.run   = 0;
          n.level = seen;
          if (seen) begin
            n.press = 1'b1;
            n.count = c.count + 8'd1;
          end else begin
            n.rel = 1'b1;
          end
        end
      end else begin
        n.run = 0;
      end
    end
    return n;
  endfunction

  always @(posedge clk) m <= model_step(m, btn_in, rst_n);

  task automatic check(input string name, input int actual, input int expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, actual, expected, $time);
    end
  endtask

  // Per-cycle comparison against the model, plus pulse tallies.
  always @(negedge clk) begin
    if (checking) begin
      check("model_level", int'(btn_level), int'(m.level));
      check("model_press", int'(btn_press), int'(m.press));
      check("model_release", int'(btn_release), int'(m.rel));
      check("model_count", int'(press_count), int'(m.count));
      check("press_release_exclusive", int'(btn_press & btn_release), 0);
      if (btn_press === 1'b1) press_pulses++;
      if (btn_release === 1'b1) release_pulses++;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycles(1);
    rst_n = 1'b1;
  endtask

  int base_p;
  int base_r;

  initial begin
    compared = 0; mismatched = 0; press_pulses = 0; release_pulses = 0;
    checking = 1'b0;
    rst_n = 1'b0;
    btn_in = 1'b0;
    cycles(2);
    rst_n = 1'b1;
    checking = 1'b1;

    // Idle after reset
    check("reset_level", int'(btn_level), 0);
    check("reset_count", int'(press_count), 0);
    cycles(20);
    check("idle_level", int'(btn_level), 0);
    check("idle_count", int'(press_count), 0);

    // Clean press: accepted after edge 7
    btn_in = 1'b1;
    cycles(6);
    check("press_e6_level", int'(btn_level), 0);
    cycles(1);
    check("press_e7_level", int'(btn_level), 1);
    check("press_e7_pulse", int'(btn_press), 1);
    cycles(1);
    check("press_e8_pulse", int'(btn_press), 0);
    check("press_e8_count", int'(press_count), 1);
    base_p = press_pulses;
    cycles(20);
    check("held_no_extra_press", press_pulses - base_p, 0);

    // Clean release
    btn_in = 1'b0;
    cycles(6);
    check("rel_e6_level", int'(btn_level), 1);
    cycles(1);
    check("rel_e7_level", int'(btn_level), 0);
    check("rel_e7_pulse", int'(btn_release), 1);
    cycles(1);
    check("rel_e8_pulse", int'(btn_release), 0);

    // Bounce: 3 high, 1 low, then steady high
    do_reset();
    base_p = press_pulses;
    btn_in = 1'b1; cycles(3);
    btn_in = 1'b0; cycles(1);
    btn_in = 1'b1;
    cycles(6);
    check("bounce_no_early_press", press_pulses - base_p, 0);
    cycles(1);
    check("bounce_e7_pulse", int'(btn_press), 1);
    check("bounce_count", int'(press_count), 1);
    cycles(10);
    check("bounce_single_pulse", press_pulses - base_p, 1);

    // Two-cycle low glitch while pressed: no release
    base_r = release_pulses;
    btn_in = 1'b0; cycles(2);
    btn_in = 1'b1;
    cycles(12);
    check("glitch_level", int'(btn_level), 1);
    check("glitch_no_release", release_pulses - base_r, 0);
    btn_in = 1'b0;
    cycles(10);
    check("final_release", release_pulses - base_r, 1);

    // Counter wrap over 256 presses
    do_reset();
    base_p = press_pulses;
    for (int i = 0; i < 255; i++) begin
      btn_in = 1'b1; cycles(8);
      btn_in = 1'b0; cycles(8);
    end
    check("count_255", int'(press_count), 255);
    btn_in = 1'b1; cycles(8);
    check("count_wrap", int'(press_count), 0);
    check("wrap_pulses", press_pulses - base_p, 256);
    btn_in = 1'b0; cycles(10);

    // Reset while in CHK_PRESS with cnt=2, released with btn_in held high
    btn_in = 1'b1;
    cycles(5);
    rst_n = 1'b0;
    cycles(1);
    check("midrst_level", int'(btn_level), 0);
    check("midrst_press", int'(btn_press), 0);
    check("midrst_release", int'(btn_release), 0);
    check("midrst_count", int'(press_count), 0);
    rst_n = 1'b1;
    cycles(6);
    check("midrst_e6_press", int'(btn_press), 0);
    cycles(1);
    check("midrst_e7_press", int'(btn_press), 1);
    check("midrst_e7_level", int'(btn_level), 1);
    cycles(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
